tenthirty_game_ctrl: RTL
========================

Name: tenthirty_game_ctrl

Overview:
- Sequencer for the ten-and-a-half card game.
- Issues single-cycle `pip` draw requests to the card LUT and captures the returned card `number`.
- Scores the player and dealer hands in half-points, runs the player/dealer turn FSM and decides each round's winner.
- Drives result LEDs; exports hand state that the 7-segment formatter renders.

Parameters:
- ROUNDS, 4, rounds per game before `led[2]` (done) asserts.
- LUT_LAT, 1, cycles from `pip` high to `number` valid (1..3).
- DEALER_STAND, 16, dealer stops drawing at `dealer_pts >= DEALER_STAND` (half-points, i.e. 8.0).
- MAX_CARDS, 5, cards per hand limit (five-card rule).

Ports:
- clk  in  1  design clock; same domain as the LUT clock.
- rst  in  1  asynchronous reset, active-high.
- btn_m  in  1  debounced single-cycle pulse: start / draw / next round.
- btn_r  in  1  debounced single-cycle pulse: player stands.
- number  in  4  card from LUT; legal range 1..13.
- pip  out  1  one-cycle draw request to LUT.
- player_pts  out  5  player total in half-points (0..31).
- dealer_pts  out  5  dealer total in half-points.
- player_cnt  out  3  player cards held (0..5).
- dealer_cnt  out  3  dealer cards held.
- last_card  out  4  most recently accepted card.
- round_idx  out  3  current round, 1..ROUNDS; 0 in IDLE.
- led  out  3  [0] player wins round, [1] dealer wins round, [2] game done.

Behaviour:
- Reset state:
  - Asynchronous on `rst` high; FSM goes to IDLE.
  - All outputs 0; internal wait counter 0.
- Card value: `number` 1..10 adds 2×number half-points; 11..13 adds 1 (0.5 point).
- Bust: a hand busts when its pts > 21 (10.5).
- Accumulators: 5-bit saturating at 31; no wrap.
- Illegal card: `number` 0 or 14..15 in a WAIT state is discarded and `pip` is re-issued next cycle. No count change.
- States and transitions:
  - IDLE: `btn_m` → P_REQ; `round_idx` ← 1; clear hands.
  - P_REQ: `pip`=1 for exactly one cycle → P_WAIT.
  - P_WAIT: wait LUT_LAT cycles, sample `number`, update `player_pts`/`player_cnt`/`last_card` → P_DECIDE.
  - P_DECIDE, in priority order:
    - bust → RESULT.
    - `player_cnt`==MAX_CARDS → RESULT (five-card win).
    - first card (`player_cnt`==1) → P_REQ automatically, so the player always holds 2 cards.
    - `btn_r` → D_REQ.
    - `btn_m` → P_REQ.
    - `btn_r` and `btn_m` in the same cycle: `btn_r` (stand) wins.
    - otherwise hold.
  - D_REQ / D_WAIT: same as P_REQ / P_WAIT, updating the dealer registers → D_DECIDE.
  - D_DECIDE: draw again (D_REQ) while `dealer_pts` < DEALER_STAND and `dealer_cnt` < MAX_CARDS and not bust; else → RESULT.
  - RESULT (1 cycle), winner in priority order:
    - player bust → dealer.
    - player five-card, not bust → player.
    - dealer bust → player.
    - `player_pts` > `dealer_pts` → player.
    - otherwise (tie included) → dealer.
    - Sets `led[0]` or `led[1]`, exactly one-hot → SHOW.
  - SHOW:
    - Hands and LEDs held.
    - On `btn_m`: if `round_idx`==ROUNDS → DONE; else `round_idx`+1, clear hands and `led[1:0]` → P_REQ.
  - DONE: `led[2]`=1; last result LEDs held; all buttons ignored; leave only via `rst`.
- Button handling: buttons are ignored in every state except IDLE, P_DECIDE and SHOW.
- `pip` is never high on two consecutive cycles, except for an illegal-card retry.
- Latency: `btn_m` in P_DECIDE → `pip` one cycle later → updated `player_pts` LUT_LAT+1 cycles after `pip`.
- Reset mid-operation, including during a WAIT: the draw is aborted and a late `number` is ignored.

Decomposition:
- Shared package `tenthirty_pkg`:
  - state enum: IDLE, P_REQ, P_WAIT, P_DECIDE, D_REQ, D_WAIT, D_DECIDE, RESULT, SHOW, DONE.
  - BUST_LIMIT=21.
  - card-to-half-point function.
- One sub-module, `tenthirty_hand`:
  - per-hand accumulator: pts, cnt, bust flag, five-card flag.
  - add / clear strobes.
  - instantiated twice (player, dealer).

Test Plan:
- `btn_m` from IDLE, LUT returns 5 then 3, then `btn_r`; dealer gets 10 → `player_pts`=16, `dealer_pts`=20 → `led`=3'b010.
- Player draws 10 then 1 (`player_pts`=22, bust) → no dealer `pip`, RESULT → `led`=3'b010, `dealer_cnt`=0.
- Player draws 12,13,11,1,2 (five cards, `player_pts`=9 half-points) → auto RESULT → `led`=3'b001.
- Dealer draws 3 then 9 (`dealer_pts`=24, bust) vs player 4+2 → `led`=3'b001; dealer 7 only (14) then 6 (26 bust) also → `led`=3'b001.
- LUT returns 0, then 15, then 7 → exactly three `pip` pulses; `player_cnt`=1 and `player_pts`=14 before the auto second draw; simultaneous `btn_m`+`btn_r` in P_DECIDE → stand taken.
- Play 4 rounds with ROUNDS=4, `btn_m` in SHOW → `led[2]`=1, later buttons ignored; assert `rst` during a P_WAIT → all outputs 0 immediately.

Source files
------------

// File: rtl/tenthirty_pkg.sv
// Shared definitions for the ten-and-a-half game controller: FSM states,
// bust threshold and the card scoring helpers (all scores in half-points).
package tenthirty_pkg;

  typedef enum logic [3:0] {
    IDLE,
    P_REQ,
    P_WAIT,
    P_DECIDE,
    D_REQ,
    D_WAIT,
    D_DECIDE,
    RESULT,
    SHOW,
    DONE
  } state_t;

  localparam int BUST_LIMIT = 21;

  // Pip cards score face value (doubled into half-points), court cards 0.5.
  function automatic logic [4:0] card_half_pts(input logic [3:0] number);
    if (number <= 4'd10) return {number, 1'b0};
    else return 5'd1;
  endfunction

  function automatic logic card_legal(input logic [3:0] number);
    return (number != 4'd0) && (number <= 4'd13);
  endfunction

endpackage

// File: rtl/tenthirty_hand.sv
// One hand's running score: saturating half-point total, card count and the
// bust / five-card flags derived from them.
module tenthirty_hand
  import tenthirty_pkg::*;
#(
  parameter int MAX_CARDS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       add,
  input  logic       clr,
  input  logic [3:0] card,
  output logic [4:0] pts,
  output logic [2:0] cnt,
  output logic       bust,
  output logic       five
);

  function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[5] ? 5'd31 : sum[4:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pts <= '0;
      cnt <= '0;
    end else if (clr) begin
      pts <= '0;
      cnt <= '0;
    end else if (add) begin
      pts <= sat_add(pts, card_half_pts(card));
      if (cnt != 3'(MAX_CARDS)) cnt <= cnt + 3'd1;
    end
  end

  assign bust = pts > 5'(BUST_LIMIT);
  assign five = cnt == 3'(MAX_CARDS);

endmodule

// File: rtl/tenthirty_game_ctrl.sv
// Ten-and-a-half round sequencer: requests cards from the LUT, scores the
// player and dealer hands, runs the turn FSM and latches the round winner.
module tenthirty_game_ctrl
  import tenthirty_pkg::*;
#(
  parameter int ROUNDS       = 4,
  parameter int LUT_LAT      = 1,
  parameter int DEALER_STAND = 16,
  parameter int MAX_CARDS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_m,
  input  logic       btn_r,
  input  logic [3:0] number,
  output logic       pip,
  output logic [4:0] player_pts,
  output logic [4:0] dealer_pts,
  output logic [2:0] player_cnt,
  output logic [2:0] dealer_cnt,
  output logic [3:0] last_card,
  output logic [2:0] round_idx,
  output logic [2:0] led
);

  state_t     state, state_nxt;
  logic [1:0] wcnt;
  logic       wait_done, card_ok;
  logic       p_add, d_add, clr_hands, round_first, round_next, go_done, win_p;
  logic       p_bust, p_five, d_bust, d_five;

  assign wait_done = wcnt == 2'(LUT_LAT);
  assign card_ok   = card_legal(number);
  assign pip       = (state == P_REQ) || (state == D_REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    p_add       = 1'b0;
    d_add       = 1'b0;
    clr_hands   = 1'b0;
    round_first = 1'b0;
    round_next  = 1'b0;
    go_done     = 1'b0;
    win_p       = 1'b0;
    case (state)
      IDLE: begin
        if (btn_m) begin
          state_nxt   = P_REQ;
          round_first = 1'b1;
          clr_hands   = 1'b1;
        end
      end
      P_REQ: state_nxt = P_WAIT;
      // An illegal card is dropped and the request is simply re-issued.
      P_WAIT: begin
        if (wait_done) begin
          if (card_ok) begin
            p_add     = 1'b1;
            state_nxt = P_DECIDE;
          end else begin
            state_nxt = P_REQ;
          end
        end
      end
      P_DECIDE: begin
        if (p_bust || p_five)         state_nxt = RESULT;
        else if (player_cnt == 3'd1)  state_nxt = P_REQ;
        else if (btn_r)               state_nxt = D_REQ;
        else if (btn_m)               state_nxt = P_REQ;
      end
      D_REQ: state_nxt = D_WAIT;
      D_WAIT: begin
        if (wait_done) begin
          if (card_ok) begin
            d_add     = 1'b1;
            state_nxt = D_DECIDE;
          end else begin
            state_nxt = D_REQ;
          end
        end
      end
      D_DECIDE: begin
        if ((dealer_pts < 5'(DEALER_STAND)) && !d_five && !d_bust) state_nxt = D_REQ;
        else state_nxt = RESULT;
      end
      // Ties and player busts go to the dealer.
      RESULT: begin
        win_p     = !p_bust && (p_five || d_bust || (player_pts > dealer_pts));
        state_nxt = SHOW;
      end
      SHOW: begin
        if (btn_m) begin
          if (round_idx == 3'(ROUNDS)) begin
            state_nxt = DONE;
            go_done   = 1'b1;
          end else begin
            state_nxt  = P_REQ;
            round_next = 1'b1;
            clr_hands  = 1'b1;
          end
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt      <= '0;
      round_idx <= '0;
      last_card <= '0;
      led       <= '0;
    end else begin
      if ((state == P_REQ) || (state == D_REQ))
        wcnt <= 2'd1;
      else if (((state == P_WAIT) || (state == D_WAIT)) && !wait_done)
        wcnt <= wcnt + 2'd1;
      else
        wcnt <= '0;

      if (round_first)     round_idx <= 3'd1;
      else if (round_next) round_idx <= round_idx + 3'd1;

      if (clr_hands)           last_card <= '0;
      else if (p_add || d_add) last_card <= number;

      if (clr_hands)             led[1:0] <= 2'b00;
      else if (state == RESULT)  led[1:0] <= win_p ? 2'b01 : 2'b10;

      if (go_done) led[2] <= 1'b1;
    end
  end

  tenthirty_hand #(.MAX_CARDS(MAX_CARDS)) u_player (
    .clk  (clk),
    .rst  (rst),
    .add  (p_add),
    .clr  (clr_hands),
    .card (number),
    .pts  (player_pts),
    .cnt  (player_cnt),
    .bust (p_bust),
    .five (p_five)
  );

  tenthirty_hand #(.MAX_CARDS(MAX_CARDS)) u_dealer (
    .clk  (clk),
    .rst  (rst),
    .add  (d_add),
    .clr  (clr_hands),
    .card (number),
    .pts  (dealer_pts),
    .cnt  (dealer_cnt),
    .bust (d_bust),
    .five (d_five)
  );

endmodule
